// File: rtl/pixel_pkg.sv
// pixel_pkg: constants and types shared by the pixel_generator front end.
//   DEF_X_SIZE / DEF_Y_SIZE : default frame geometry (pixels per line, lines)
//   COORD_W / FRAC_W        : signed coordinate format (sign + Q2.22)
//   BASE_STEP               : per-pixel step at zoom 0 (3.0 / DEF_X_SIZE, truncated)
//   scan_state_e            : coord_scanner FSM encoding
//   half_size()             : half-frame constants used for the frame origin
//   mul_const()             : constant multiply written as a shift-add chain
package pixel_pkg;

    localparam int DEF_X_SIZE = 1280;
    localparam int DEF_Y_SIZE = 720;
    localparam int DEF_ZOOM_W = 3;
    localparam int COORD_W    = 25;
    localparam int FRAC_W     = 22;

    // 3.0 in Q.22 divided across one line of the default geometry: 9830.
    localparam logic [COORD_W-1:0] BASE_STEP = COORD_W'((3 << FRAC_W) / DEF_X_SIZE);

    typedef enum logic [1:0] {
        LOAD_STEP   = 2'b00,
        LOAD_ORIGIN = 2'b01,
        RUN         = 2'b10
    } scan_state_e;

    function automatic int unsigned half_size(input int unsigned n);
        return n >> 1;
    endfunction

    // Multiply by an elaboration-time constant; each set bit of k contributes
    // one shifted copy of v. Result wraps to COORD_W bits.
    function automatic logic [COORD_W-1:0] mul_const(input logic [COORD_W-1:0] v,
                                                     input int unsigned k);
        logic [COORD_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) acc = acc + (v << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position counters for coord_scanner.
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : step to the next pixel (x fastest, wraps to (0,0) after the frame)
//   first      : x == 0 && y == 0
//   last_x     : x == X_SIZE-1
//   last_y     : y == Y_SIZE-1
//   wrap       : current pixel is the last of the frame
module raster_counter #(
    parameter int X_SIZE = 1280,
    parameter int Y_SIZE = 720
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output logic first,
    output logic last_x,
    output logic last_y,
    output logic wrap
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign first  = (x_q == '0) && (y_q == '0);
    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);
    assign wrap   = last_x && last_y;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (!last_x) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/coord_scanner.sv
// coord_scanner: raster-order complex-plane point generator feeding the
// fractal iteration engine. One point per pixel, x fastest, screen y downward.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   zoom                 : step = BASE_STEP >> zoom, sampled once per frame
//   x_offset, y_offset   : frame centre (signed), sampled once per frame
//   c_re, c_im           : current point (signed, sign + Q2.22)
//   first/last_x/last_y  : raster position flags for the current point
//   out_valid, out_ready : output handshake
//   frame_count          : frames completed (only with COORD_SCANNER_FRAME_COUNT_EN)
//   dbg_state            : FSM state, for observation only
// Handshake: a point transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, every output holds; out_valid only
// drops after the last point of a frame has transferred.
// Optional build macro: COORD_SCANNER_FRAME_COUNT_EN adds the frame_count port.
module coord_scanner
    import pixel_pkg::*;
#(
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int Y_SIZE = DEF_Y_SIZE,
    parameter int ZOOM_W = DEF_ZOOM_W
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ZOOM_W-1:0]         zoom,
    input  logic [COORD_W-1:0]        x_offset,
    input  logic [COORD_W-1:0]        y_offset,
    output logic [COORD_W-1:0]        c_re,
    output logic [COORD_W-1:0]        c_im,
    output logic                      first,
    output logic                      last_x,
    output logic                      last_y,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef COORD_SCANNER_FRAME_COUNT_EN
    output logic [15:0]               frame_count,
`endif
    output logic [1:0]                dbg_state
);

    localparam int unsigned X_HALF = half_size(X_SIZE);
    localparam int unsigned Y_HALF = half_size(Y_SIZE);

    scan_state_e state_q, state_d;
    logic [COORD_W-1:0] step_q, step_d;
    logic [COORD_W-1:0] x_off_q, x_off_d;
    logic [COORD_W-1:0] y_off_q, y_off_d;
    logic [COORD_W-1:0] row_start_q, row_start_d;
    logic [COORD_W-1:0] cur_re_q, cur_re_d;
    logic [COORD_W-1:0] cur_im_q, cur_im_d;
    logic advance;
    logic run;
    logic cnt_first, cnt_last_x, cnt_last_y, cnt_wrap;

    raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_raster (
        .clk     (aclk),
        .rst_n   (aresetn),
        .advance (advance),
        .first   (cnt_first),
        .last_x  (cnt_last_x),
        .last_y  (cnt_last_y),
        .wrap    (cnt_wrap)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        x_off_d     = x_off_q;
        y_off_d     = y_off_q;
        row_start_d = row_start_q;
        cur_re_d    = cur_re_q;
        cur_im_d    = cur_im_q;
        advance     = 1'b0;
        case (state_q)
            LOAD_STEP: begin
                step_d  = BASE_STEP >> zoom;
                x_off_d = x_offset;
                y_off_d = y_offset;
                state_d = LOAD_ORIGIN;
            end
            LOAD_ORIGIN: begin
                // Top-left pixel: centre minus half a line, plus half a frame
                // upward (imaginary axis points up, screen y points down).
                row_start_d = x_off_q - mul_const(step_q, X_HALF);
                cur_re_d    = row_start_d;
                cur_im_d    = y_off_q + mul_const(step_q, Y_HALF);
                state_d     = RUN;
            end
            RUN: begin
                if (out_ready) begin
                    advance = 1'b1;
                    if (!cnt_last_x) begin
                        cur_re_d = cur_re_q + step_q;
                    end else if (!cnt_wrap) begin
                        cur_re_d = row_start_q;
                        cur_im_d = cur_im_q - step_q;
                    end else begin
                        state_d = LOAD_STEP;
                    end
                end
            end
            default: state_d = LOAD_STEP;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= LOAD_STEP;
            step_q      <= '0;
            x_off_q     <= '0;
            y_off_q     <= '0;
            row_start_q <= '0;
            cur_re_q    <= '0;
            cur_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            x_off_q     <= x_off_d;
            y_off_q     <= y_off_d;
            row_start_q <= row_start_d;
            cur_re_q    <= cur_re_d;
            cur_im_q    <= cur_im_d;
        end
    end

`ifdef COORD_SCANNER_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt_q <= '0;
        end else if (advance && cnt_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

    // Flags are qualified by RUN so that they read 0 in reset and in the
    // frame bubble, where the counters already sit at (0,0).
    assign run       = (state_q == RUN);
    assign out_valid = run;
    assign first     = run && cnt_first;
    assign last_x    = run && cnt_last_x;
    assign last_y    = run && cnt_last_y;
    assign c_re      = cur_re_q;
    assign c_im      = cur_im_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_coord_scanner.sv
module tb_coord_scanner;
  import pixel_pkg::*;

  localparam int XS = 4;
  localparam int YS = 2;
  localparam int PW = 2 * COORD_W + 3;

  // clock / reset
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [2:0]         zoom = '0;
  logic [COORD_W-1:0] x_offset = '0;
  logic [COORD_W-1:0] y_offset = '0;
  logic               out_ready = 1'b0;
  logic [COORD_W-1:0] c_re, c_im;
  logic               first, last_x, last_y, out_valid;
  logic [1:0]         dbg_state;
`ifdef COORD_SCANNER_FRAME_COUNT_EN
  logic [15:0]        frame_count;
`endif

  coord_scanner #(.X_SIZE(XS), .Y_SIZE(YS), .ZOOM_W(3)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .zoom      (zoom),
    .x_offset  (x_offset),
    .y_offset  (y_offset),
    .c_re      (c_re),
    .c_im      (c_im),
    .first     (first),
    .last_x    (last_x),
    .last_y    (last_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef COORD_SCANNER_FRAME_COUNT_EN
    .frame_count (frame_count),
`endif
    .dbg_state (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic in_bubble = 1'b0;
  int bubble = 0;
  logic [15:0] exp_fc = '0;
  logic fc_pending = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected points of one frame, computed directly from pixel position.
  task automatic push_frame(input logic [2:0] z, input logic [COORD_W-1:0] xo,
                            input logic [COORD_W-1:0] yo);
    logic [COORD_W-1:0] st, rs, im0, re, im;
    st  = 25'd9830 >> z;
    rs  = xo - st * 25'(XS / 2);
    im0 = yo + st * 25'(YS / 2);
    for (int y = 0; y < YS; y++) begin
      for (int x = 0; x < XS; x++) begin
        re = rs + st * 25'(x);
        im = im0 - st * 25'(y);
        exp_q.push_back({re, im, (x == 0 && y == 0), (x == XS - 1), (y == YS - 1)});
      end
    end
  endtask

  // driver + monitor; called and returns at a falling edge
  task automatic collect(input int npts, input int pct, input int max_cyc);
    int got = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [PW:0] prev_obs = '0;
    logic [PW:0] obs;
    logic [PW-1:0] e;
    while (got < npts && cyc < max_cyc) begin
      out_ready = ($urandom_range(0, 99) < pct);
      obs = {out_valid, c_re, c_im, first, last_x, last_y};
      if (fc_pending) begin
`ifdef COORD_SCANNER_FRAME_COUNT_EN
        chk("frame_count", 64'(frame_count), 64'(exp_fc));
`endif
        fc_pending = 1'b0;
      end
      if (prev_stall) chk("stall_hold", 64'(obs), 64'(prev_obs));
      if (!out_valid) begin
        if (in_bubble) bubble++;
      end else begin
        if (in_bubble) begin
          chk("bubble_len", 64'(bubble), 64'd2);
          in_bubble = 1'b0;
        end
        if (out_ready) begin
          chk("exp_avail", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("point", 64'(obs[PW-1:0]), 64'(e));
            if (e[0] && e[1]) begin
              in_bubble = 1'b1;
              bubble = 0;
              exp_fc++;
              fc_pending = 1'b1;
            end
          end
          got++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
      cyc++;
      @(negedge aclk);
    end
    if (got < npts) chk("collect_timeout", 64'(got), 64'(npts));
  endtask

  // called at the falling edge where aresetn was released
  task automatic wait_first();
    @(negedge aclk);
    chk("latency_cyc1_valid", 64'(out_valid), 64'd0);
    @(negedge aclk);
    chk("latency_cyc2_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_c_re", 64'(c_re), 64'd0);
    chk("rst_c_im", 64'(c_im), 64'd0);
    chk("rst_flags", 64'({first, last_x, last_y, out_valid}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(LOAD_STEP));
    repeat (2) @(negedge aclk);

    // 1: zoom 0, offsets 0, always ready, two frames to see the bubble
    zoom = 3'd0; x_offset = '0; y_offset = '0;
    push_frame(3'd0, '0, '0);
    push_frame(3'd0, '0, '0);
    aresetn = 1'b1;
    wait_first();
    chk("t1_first_re", 64'(c_re), 64'(25'h1FFB334)); // -19660
    chk("t1_first_im", 64'(c_im), 64'd9830);
    collect(16, 100, 100);

    // 2: zoom 3, step 1228
    zoom = 3'd3; x_offset = 25'd50000;
    push_frame(3'd3, 25'd50000, '0);
    collect(8, 100, 100);

    // 3: random ready over two frames, negative imaginary centre
    zoom = 3'd1; x_offset = 25'h1FFF000; y_offset = 25'h1FF0000;
    push_frame(3'd1, 25'h1FFF000, 25'h1FF0000);
    push_frame(3'd1, 25'h1FFF000, 25'h1FF0000);
    collect(16, 50, 400);

    // 4: offset change mid-frame only takes effect on the next frame
    zoom = 3'd0; x_offset = '0; y_offset = 25'd1000;
    push_frame(3'd0, '0, 25'd1000);
    collect(3, 100, 100);
    x_offset = 25'd100000;
    collect(5, 100, 100);
    push_frame(3'd0, 25'd100000, 25'd1000);
    collect(8, 100, 100);

    // 6: maximum positive offset wraps to negative across the line
    x_offset = 25'h0FFFFFF; y_offset = '0;
    push_frame(3'd0, 25'h0FFFFFF, '0);
    push_frame(3'd0, 25'h0FFFFFF, '0);
    push_frame(3'd0, 25'h0FFFFFF, '0);
    collect(24, 70, 400);

    // 5: asynchronous reset mid-frame while stalled
    zoom = 3'd2; x_offset = '0; y_offset = '0;
    push_frame(3'd2, '0, '0);
    collect(6, 100, 100);
    out_ready = 1'b0;
    @(negedge aclk);
    chk("t5_stalled_valid", 64'(out_valid), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("t5_rst_c_re", 64'(c_re), 64'd0);
    chk("t5_rst_c_im", 64'(c_im), 64'd0);
    chk("t5_rst_flags", 64'({first, last_x, last_y, out_valid}), 64'd0);
    chk("t5_rst_state", 64'(dbg_state), 64'(LOAD_STEP));
`ifdef COORD_SCANNER_FRAME_COUNT_EN
    chk("t5_rst_frame_count", 64'(frame_count), 64'd0);
`endif
    exp_q.delete();
    in_bubble = 1'b0;
    fc_pending = 1'b0;
    exp_fc = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    push_frame(3'd2, '0, '0);
    wait_first();
    chk("t5_restart_first", 64'(first), 64'd1);
    collect(8, 100, 100);
    if (fc_pending) begin
`ifdef COORD_SCANNER_FRAME_COUNT_EN
      chk("frame_count_final", 64'(frame_count), 64'(exp_fc));
`endif
      fc_pending = 1'b0;
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
